// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences single read/write cycles on the external memory
// data bus through the octal bus transceiver. Each cycle runs SETUP, STROBE
// and HOLD phases of configurable length. All bus and response outputs are
// registered, so the pins switch cleanly on clock edges only.
module bus_cycle_ctrl #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       xcvr_dir,
    output logic       xcvr_noe,
    output logic       mem_nwe,
    output logic       mem_noe,
    output logic [7:0] bus_out,
    input  logic [7:0] bus_in
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Counter preload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       write_r;
    logic       write_s;
    logic       accept_s;
    logic       capture_s;
    logic       done_s;

    logic       ready_r;
    logic       busy_r;
    logic       rsp_valid_r;
    logic [7:0] rdata_r;
    logic       dir_r;
    logic       xnoe_r;
    logic       nwe_r;
    logic       moe_r;
    logic [7:0] bus_out_r;

    logic       xnoe_s;
    logic       nwe_s;
    logic       moe_s;

    // Next-state and phase-counter logic; read capture and completion flags.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        write_s   = write_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    write_s  = req_write;
                    state_s  = ST_SETUP;
                    cnt_s    = SETUP_LOAD;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_STROBE;
                    cnt_s   = STROBE_LOAD;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s   = ST_HOLD;
                    cnt_s     = HOLD_LOAD;
                    capture_s = ~write_r;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Bus strobe levels for the state being entered, so the registered pins
    // line up exactly with the state they belong to.
    always_comb begin
        xnoe_s = 1'b1;
        nwe_s  = 1'b1;
        moe_s  = 1'b1;
        case (state_s)
            ST_IDLE: begin
                xnoe_s = 1'b1;
                nwe_s  = 1'b1;
                moe_s  = 1'b1;
            end
            ST_SETUP: begin
                // Transceiver stays disabled while DIR settles.
                xnoe_s = 1'b1;
                nwe_s  = 1'b1;
                moe_s  = write_s;
            end
            ST_STROBE: begin
                xnoe_s = 1'b0;
                nwe_s  = ~write_s;
                moe_s  = write_s;
            end
            ST_HOLD: begin
                // Writes keep data driven through hold; reads release early.
                xnoe_s = ~write_s;
                nwe_s  = 1'b1;
                moe_s  = 1'b1;
            end
            default: begin
                xnoe_s = 1'b1;
                nwe_s  = 1'b1;
                moe_s  = 1'b1;
            end
        endcase
    end

    // FSM state, phase counter and latched transfer direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            write_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            write_r <= write_s;
        end
    end

    // Registered outputs: strobes, direction, write data, read data, handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 8'h00;
            dir_r       <= 1'b0;
            xnoe_r      <= 1'b1;
            nwe_r       <= 1'b1;
            moe_r       <= 1'b1;
            bus_out_r   <= 8'h00;
        end else begin
            ready_r     <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            rsp_valid_r <= done_s;
            xnoe_r      <= xnoe_s;
            nwe_r       <= nwe_s;
            moe_r       <= moe_s;
            if (capture_s) begin
                rdata_r <= bus_in;
            end else begin
                rdata_r <= rdata_r;
            end
            // DIR only moves on accept, when the transceiver is disabled.
            if (accept_s) begin
                dir_r <= req_write;
            end else begin
                dir_r <= dir_r;
            end
            if (accept_s && req_write) begin
                bus_out_r <= req_wdata;
            end else begin
                bus_out_r <= bus_out_r;
            end
        end
    end

    // req_ready is held low for as long as reset is asserted.
    assign req_ready = ready_r & ~rst;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign xcvr_dir  = dir_r;
    assign xcvr_noe  = xnoe_r;
    assign mem_nwe   = nwe_r;
    assign mem_noe   = moe_r;
    assign bus_out   = bus_out_r;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed self-checking bench for bus_cycle_ctrl: default timing instance
// plus a second instance with S=2, T=3, H=2.
module tb_bus_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_wdata;
    logic [7:0] bus_in;
    logic       req_ready, rsp_valid, busy, xcvr_dir, xcvr_noe, mem_nwe, mem_noe;
    logic [7:0] rsp_rdata, bus_out;

    logic       p_req_valid;
    logic       p_req_ready, p_rsp_valid, p_busy, p_xcvr_dir, p_xcvr_noe, p_mem_nwe, p_mem_noe;
    logic [7:0] p_rsp_rdata, p_bus_out;

    int check_count = 0;
    int error_count = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    bus_cycle_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .busy(busy), .xcvr_dir(xcvr_dir), .xcvr_noe(xcvr_noe),
        .mem_nwe(mem_nwe), .mem_noe(mem_noe), .bus_out(bus_out), .bus_in(bus_in)
    );

    bus_cycle_ctrl #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut_p (
        .clk(clk), .rst(rst), .req_valid(p_req_valid), .req_ready(p_req_ready),
        .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(p_rsp_valid),
        .rsp_rdata(p_rsp_rdata), .busy(p_busy), .xcvr_dir(p_xcvr_dir), .xcvr_noe(p_xcvr_noe),
        .mem_nwe(p_mem_nwe), .mem_noe(p_mem_noe), .bus_out(p_bus_out), .bus_in(bus_in)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write and read strobes must never be low together on either instance.
    always @(negedge clk) begin
        if (mon_en) begin
            check_val("excl", 32'(mem_nwe | mem_noe), 32'd1);
            check_val("p_excl", 32'(p_mem_nwe | p_mem_noe), 32'd1);
        end
    end

    int dir_changes;
    int rv_count;
    int rv_first;
    int rv_second;
    logic prev_dir;

    initial begin
        rst = 1'b1; req_valid = 1'b0; p_req_valid = 1'b0;
        req_write = 1'b0; req_wdata = 8'h00; bus_in = 8'hFF;

        // ---------------- reset values ----------------
        @(posedge clk);
        @(negedge clk);
        check_val("rst_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_xnoe", 32'(xcvr_noe), 32'd1);
        check_val("rst_nwe", 32'(mem_nwe), 32'd1);
        check_val("rst_noe", 32'(mem_noe), 32'd1);
        check_val("rst_dir", 32'(xcvr_dir), 32'd0);
        check_val("rst_bus_out", 32'(bus_out), 32'h00);
        check_val("rst_rdata", 32'(rsp_rdata), 32'h00);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_p_ready", 32'(p_req_ready), 32'd1);
        mon_en = 1'b1;

        // ---------------- write 0xA5 ----------------
        @(negedge clk);
        req_write = 1'b1; req_wdata = 8'hA5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = 8'h00;
        for (int c = 1; c <= 5; c++) begin
            check_val("wr_dir", 32'(xcvr_dir), 32'd1);
            check_val("wr_nwe", 32'(mem_nwe), (c == 2 || c == 3) ? 32'd0 : 32'd1);
            check_val("wr_noe", 32'(mem_noe), 32'd1);
            check_val("wr_xnoe", 32'(xcvr_noe), (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
            check_val("wr_bus_out", 32'(bus_out), 32'hA5);
            check_val("wr_rsp_valid", 32'(rsp_valid), (c == 5) ? 32'd1 : 32'd0);
            check_val("wr_busy", 32'(busy), (c <= 4) ? 32'd1 : 32'd0);
            check_val("wr_ready", 32'(req_ready), (c == 5) ? 32'd1 : 32'd0);
            check_val("wr_rdata", 32'(rsp_rdata), 32'h00);
            @(negedge clk);
        end

        // ---------------- read, capture at end of cycle 3 ----------------
        req_write = 1'b0; req_wdata = 8'hEE; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            bus_in = (c == 2) ? 8'h55 : (c == 3) ? 8'h3C : 8'hFF;
            check_val("rd_dir", 32'(xcvr_dir), 32'd0);
            check_val("rd_noe", 32'(mem_noe), (c <= 3) ? 32'd0 : 32'd1);
            check_val("rd_nwe", 32'(mem_nwe), 32'd1);
            check_val("rd_xnoe", 32'(xcvr_noe), (c == 2 || c == 3) ? 32'd0 : 32'd1);
            check_val("rd_bus_out", 32'(bus_out), 32'hA5);
            check_val("rd_rsp_valid", 32'(rsp_valid), (c == 5) ? 32'd1 : 32'd0);
            check_val("rd_rdata", 32'(rsp_rdata), (c >= 4) ? 32'h3C : 32'h00);
            @(negedge clk);
        end

        // ---------------- back-to-back write 0x11 then read ----------------
        req_write = 1'b1; req_wdata = 8'h11; req_valid = 1'b1;
        prev_dir = xcvr_dir;
        dir_changes = 0; rv_count = 0; rv_first = 0; rv_second = 0;
        @(negedge clk);
        req_write = 1'b0; req_wdata = 8'h99; bus_in = 8'h42;
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) req_valid = 1'b0;
            if (xcvr_dir !== prev_dir) begin
                dir_changes++;
                check_val("b2b_dir_noe", 32'(xcvr_noe), 32'd1);
            end
            prev_dir = xcvr_dir;
            if (rsp_valid === 1'b1) begin
                rv_count++;
                if (rv_count == 1) rv_first = k;
                else rv_second = k;
            end
            if (k == 5) check_val("b2b_ready", 32'(req_ready), 32'd1);
            if (k == 6) check_val("b2b_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check_val("b2b_dir_changes", 32'(dir_changes), 32'd2);
        check_val("b2b_rsp_count", 32'(rv_count), 32'd2);
        check_val("b2b_first", 32'(rv_first), 32'd5);
        check_val("b2b_spacing", 32'(rv_second - rv_first), 32'd5);
        check_val("b2b_bus_out", 32'(bus_out), 32'h11);
        check_val("b2b_rdata", 32'(rsp_rdata), 32'h42);

        // ---------------- reset during STROBE of a write ----------------
        req_write = 1'b1; req_wdata = 8'h77; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_val("mid_in_strobe", 32'(mem_nwe), 32'd0);
        rst = 1'b1;
        #1;
        check_val("mid_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mid_nwe", 32'(mem_nwe), 32'd1);
        check_val("mid_noe", 32'(mem_noe), 32'd1);
        check_val("mid_xnoe", 32'(xcvr_noe), 32'd1);
        check_val("mid_dir", 32'(xcvr_dir), 32'd0);
        check_val("mid_bus_out", 32'(bus_out), 32'h00);
        check_val("mid_rdata", 32'(rsp_rdata), 32'h00);
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check_val("mid_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        req_write = 1'b0; req_valid = 1'b1; bus_in = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check_val("mid_rd_rsp_valid", 32'(rsp_valid), (c == 5) ? 32'd1 : 32'd0);
            check_val("mid_rd_rdata", 32'(rsp_rdata), (c >= 4) ? 32'h5A : 32'h00);
            @(negedge clk);
        end

        // ---------------- S=2 T=3 H=2 read ----------------
        req_write = 1'b0; p_req_valid = 1'b1; bus_in = 8'hEE;
        @(negedge clk);
        p_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            bus_in = (c == 4) ? 8'h10 : (c == 5) ? 8'hC3 : 8'hEE;
            check_val("p_rd_noe", 32'(p_mem_noe), (c <= 5) ? 32'd0 : 32'd1);
            check_val("p_rd_xnoe", 32'(p_xcvr_noe), (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
            check_val("p_rd_rsp_valid", 32'(p_rsp_valid), (c == 8) ? 32'd1 : 32'd0);
            check_val("p_rd_busy", 32'(p_busy), (c <= 7) ? 32'd1 : 32'd0);
            check_val("p_rd_rdata", 32'(p_rsp_rdata), (c >= 6) ? 32'hC3 : 32'h00);
            @(negedge clk);
        end

        // ---------------- S=2 T=3 H=2 write ----------------
        req_write = 1'b1; req_wdata = 8'hD2; p_req_valid = 1'b1;
        @(negedge clk);
        p_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_val("p_wr_dir", 32'(p_xcvr_dir), 32'd1);
            check_val("p_wr_nwe", 32'(p_mem_nwe), (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
            check_val("p_wr_xnoe", 32'(p_xcvr_noe), (c >= 3 && c <= 7) ? 32'd0 : 32'd1);
            check_val("p_wr_bus_out", 32'(p_bus_out), 32'hD2);
            check_val("p_wr_rsp_valid", 32'(p_rsp_valid), (c == 8) ? 32'd1 : 32'd0);
            check_val("p_wr_rdata", 32'(p_rsp_rdata), 32'hC3);
            @(negedge clk);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
